// File: rtl/multichannel_timebase_shifter.sv
// -----------------------------------------------------------------------------
// multichannel_timebase_shifter
//
// Phase-shift timebase for the PWM generator. Each of N_CHANNELS channels
// delays the start of its carrier counter by a programmable number of
// prescaled enable ticks after the common period sync.
//
// Each channel holds:
//   - an active shift value,
//   - a down-counter,
//   - a three-state FSM (IDLE / ARMED / RUNNING).
//
// A sync arms every channel and loads its counter from the shift value. An
// ARMED channel:
//   - counts down on enable ticks;
//   - when its counter reaches zero, emits a one-cycle counter_start and moves
//     to RUNNING.
// A RUNNING channel holds counter_enable high until:
//   - the next sync re-arms it, or
//   - a stop returns it to IDLE.
//
// Optional feature, selected by the macro TIMEBASE_SHIFTER_SHADOW_EN:
//   - Defined: load writes a per-channel shadow register. The shadow is copied
//     into the active shift value on each sync. A load never disturbs a
//     running count.
//   - Undefined (default): load writes the active shift value directly. An
//     ARMED channel also takes the new value into its counter immediately.
//
// Parameters:
//   N_CHANNELS     number of independent shift channels (1..16)
//   COUNTER_WIDTH  width of shift values and counters
//
// Ports:
//   clockIn         system clock, all registers update on its rising edge
//   reset           synchronous active-high reset, clears all state
//   enable          prescaled tick; ARMED counters decrement only when high
//   sync            period-start strobe, arms every channel
//   stop            disarms every channel (beats sync and expiry)
//   load            per-channel write strobe for shift_in
//   shift_in        packed shift values, channel i at [i*W +: W]
//   count_out       packed live counter values, same packing
//   counter_start   one-cycle pulse when a channel's delay expires
//   counter_enable  high while the channel is RUNNING
//   busy            high while any channel is ARMED
// -----------------------------------------------------------------------------
module multichannel_timebase_shifter #(
    parameter int N_CHANNELS    = 4,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                                clockIn,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                sync,
    input  logic                                stop,
    input  logic [N_CHANNELS-1:0]               load,
    input  logic [N_CHANNELS*COUNTER_WIDTH-1:0] shift_in,
    output logic [N_CHANNELS*COUNTER_WIDTH-1:0] count_out,
    output logic [N_CHANNELS-1:0]               counter_start,
    output logic [N_CHANNELS-1:0]               counter_enable,
    output logic                                busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUNNING = 2'd2
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE = COUNTER_WIDTH'(1);

    // Per-channel "will be ARMED after this edge", gathered for the busy flop.
    logic [N_CHANNELS-1:0] armed_next;
    logic                  busy_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_CHANNELS; gi++) begin : g_chan
            state_t                   state_reg;
            state_t                   state_next;
            logic [COUNTER_WIDTH-1:0] shift_reg;
            logic [COUNTER_WIDTH-1:0] shift_next;
            logic [COUNTER_WIDTH-1:0] count_reg;
            logic [COUNTER_WIDTH-1:0] count_next;
            logic [COUNTER_WIDTH-1:0] load_value;
            logic [COUNTER_WIDTH-1:0] reload_value;
            logic                     start_reg;
            logic                     start_next;
            logic                     run_reg;
`ifdef TIMEBASE_SHIFTER_SHADOW_EN
            logic [COUNTER_WIDTH-1:0] shadow_reg;
            logic [COUNTER_WIDTH-1:0] shadow_next;
`endif

            assign load_value = shift_in[gi*COUNTER_WIDTH +: COUNTER_WIDTH];

            // Shift-value bookkeeping and the value a sync loads into the
            // counter.
            always_comb begin : p_shift_next
`ifdef TIMEBASE_SHIFTER_SHADOW_EN
                // A sync uses the shadow content from before this edge. A
                // load on the same edge is only seen at the following sync.
                shadow_next  = load[gi] ? load_value : shadow_reg;
                shift_next   = sync ? shadow_reg : shift_reg;
                reload_value = shadow_reg;
`else
                // Direct write: a load coinciding with sync must arm with the
                // freshly written value, so reload from the next shift value.
                shift_next   = load[gi] ? load_value : shift_reg;
                reload_value = shift_next;
`endif
            end

            // Channel FSM.
            // Priority: stop > sync > (direct-mode load) > expiry > decrement.
            // A sync arriving while ARMED restarts the delay from the shift
            // value (new period), even if the old delay was just expiring.
            always_comb begin : p_fsm_next
                state_next = state_reg;
                count_next = count_reg;
                start_next = 1'b0;
                if (stop) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end else if (sync) begin
                    state_next = ST_ARMED;
                    count_next = reload_value;
                end else begin
                    case (state_reg)
                        ST_IDLE: begin
                            count_next = count_reg;
                        end
                        ST_ARMED: begin
`ifndef TIMEBASE_SHIFTER_SHADOW_EN
                            // A direct load re-times the pending delay; the
                            // expiry check then runs on the new value.
                            if (load[gi]) begin
                                count_next = load_value;
                            end else
`endif
                            if (count_reg == '0) begin
                                state_next = ST_RUNNING;
                                start_next = 1'b1;
                            end else if (enable) begin
                                count_next = count_reg - COUNT_ONE;
                            end
                        end
                        ST_RUNNING: begin
                            count_next = '0;
                        end
                        default: begin
                            state_next = ST_IDLE;
                            count_next = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clockIn) begin : p_chan_regs
                if (reset) begin
                    state_reg  <= ST_IDLE;
                    shift_reg  <= '0;
                    count_reg  <= '0;
                    start_reg  <= 1'b0;
                    run_reg    <= 1'b0;
`ifdef TIMEBASE_SHIFTER_SHADOW_EN
                    shadow_reg <= '0;
`endif
                end else begin
                    state_reg  <= state_next;
                    shift_reg  <= shift_next;
                    count_reg  <= count_next;
                    start_reg  <= start_next;
                    run_reg    <= (state_next == ST_RUNNING);
`ifdef TIMEBASE_SHIFTER_SHADOW_EN
                    shadow_reg <= shadow_next;
`endif
                end
            end

            assign armed_next[gi]                                   = (state_next == ST_ARMED);
            assign count_out[gi*COUNTER_WIDTH +: COUNTER_WIDTH]     = count_reg;
            assign counter_start[gi]                                = start_reg;
            assign counter_enable[gi]                               = run_reg;
        end
    endgenerate

    // busy mirrors "any channel ARMED" in the same cycle as the states. It
    // therefore drops together with the last channel's counter_start.
    always_ff @(posedge clockIn) begin : p_busy
        if (reset) begin
            busy_reg <= 1'b0;
        end else begin
            busy_reg <= |armed_next;
        end
    end

    assign busy = busy_reg;

endmodule
